// File: rtl/membrane_accum_pkg.sv
// Shared widths, FSM state type and saturating adder for the
// membrane accumulator and its threshold/fire datapath.
package snn_pkg;

   localparam int WIDTH_IN  = 13;
   localparam int WIDTH_MEM = 16;

   typedef enum logic [2:0] {
      IDLE,
      RX_ACK,
      RX_REL,
      FIRE,
      TX_REQ,
      TX_REL
   } state_t;

   function automatic logic [WIDTH_MEM-1:0] sat_add(
      input logic [WIDTH_MEM-1:0] a,
      input logic [WIDTH_MEM-1:0] b
   );
      logic [WIDTH_MEM:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[WIDTH_MEM] ? '1 : s[WIDTH_MEM-1:0];
   endfunction

endpackage

// File: rtl/membrane_accum_if.sv
// Four-phase partial-sum input channel and spike output channel.
// slave = membrane_accum side, master = surrounding pipeline side.
interface membrane_accum_if;
   import snn_pkg::*;

   logic                 L_req;
   logic [WIDTH_IN-1:0]  L_data;
   logic                 L_ack;
   logic                 R_req;
   logic                 R_ack;
   logic                 R_spike;
   logic [WIDTH_MEM-1:0] R_potential;

   modport slave (
      input  L_req, L_data, R_ack,
      output L_ack, R_req, R_spike, R_potential
   );

   modport master (
      output L_req, L_data, R_ack,
      input  L_ack, R_req, R_spike, R_potential
   );

endinterface

// File: rtl/membrane_accum_threshold_fire.sv
// Combinational add/compare/subtract of one timestep's contribution.
// MEM_LEAK_EN: vmem is leaked by LEAK (clamped at 0) before the add.
module threshold_fire
   import snn_pkg::*;
#(
   parameter int THRESHOLD = 64
`ifdef MEM_LEAK_EN
   ,
   parameter int LEAK      = 1
`endif
) (
   input  logic [WIDTH_MEM-1:0] i_vmem,
   input  logic [WIDTH_MEM-1:0] i_acc,
   output logic                 o_spike,
   output logic [WIDTH_MEM-1:0] o_vmem_next
);

   localparam logic [WIDTH_MEM-1:0] THR = WIDTH_MEM'(THRESHOLD);

   logic [WIDTH_MEM-1:0] w_base;
   logic [WIDTH_MEM-1:0] w_sum;

`ifdef MEM_LEAK_EN
   localparam logic [WIDTH_MEM-1:0] LK = WIDTH_MEM'(LEAK);
   assign w_base = (i_vmem > LK) ? i_vmem - LK : '0;
`else
   assign w_base = i_vmem;
`endif

   assign w_sum       = sat_add(w_base, i_acc);
   assign o_spike     = (w_sum >= THR);
   assign o_vmem_next = o_spike ? w_sum - THR : w_sum;

endmodule

// File: rtl/membrane_accum.sv
// Accumulates NUM_PSUM partial sums per timestep, integrates and fires.
// Optional MEM_LEAK_EN adds a per-timestep leak inside threshold_fire.
module membrane_accum
   import snn_pkg::*;
#(
   parameter int NUM_PSUM  = 4,
   parameter int THRESHOLD = 64
`ifdef MEM_LEAK_EN
   ,
   parameter int LEAK      = 1
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   membrane_accum_if.slave  bus,
   output logic             busy
);

   localparam logic [3:0] NUM_P = 4'(NUM_PSUM);

   state_t               r_state, w_state;
   logic [WIDTH_MEM-1:0] r_acc, w_acc;
   logic [3:0]           r_cnt, w_cnt;
   logic [WIDTH_MEM-1:0] r_vmem, w_vmem;
   logic                 r_l_ack, w_l_ack;
   logic                 r_r_req, w_r_req;
   logic                 r_spike, w_spike;
   logic [WIDTH_MEM-1:0] r_pot, w_pot;

   logic                 w_tf_spike;
   logic [WIDTH_MEM-1:0] w_tf_vmem;

   threshold_fire #(
      .THRESHOLD (THRESHOLD)
`ifdef MEM_LEAK_EN
      ,
      .LEAK      (LEAK)
`endif
   ) u_fire (
      .i_vmem      (r_vmem),
      .i_acc       (r_acc),
      .o_spike     (w_tf_spike),
      .o_vmem_next (w_tf_vmem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_vmem  <= '0;
         r_l_ack <= 1'b0;
         r_r_req <= 1'b0;
         r_spike <= 1'b0;
         r_pot   <= '0;
      end else begin
         r_state <= w_state;
         r_acc   <= w_acc;
         r_cnt   <= w_cnt;
         r_vmem  <= w_vmem;
         r_l_ack <= w_l_ack;
         r_r_req <= w_r_req;
         r_spike <= w_spike;
         r_pot   <= w_pot;
      end
   end

   always_comb begin
      w_state = r_state;
      w_acc   = r_acc;
      w_cnt   = r_cnt;
      w_vmem  = r_vmem;
      w_l_ack = r_l_ack;
      w_r_req = r_r_req;
      w_spike = r_spike;
      w_pot   = r_pot;
      unique case (r_state)
         IDLE: begin
            if (bus.L_req) w_state = RX_ACK;
         end
         RX_ACK: begin
            w_acc   = sat_add(r_acc, WIDTH_MEM'(bus.L_data));
            w_cnt   = r_cnt + 4'd1;
            w_l_ack = 1'b1;
            w_state = RX_REL;
         end
         RX_REL: begin
            if (!bus.L_req) begin
               w_l_ack = 1'b0;
               w_state = (r_cnt == NUM_P) ? FIRE : IDLE;
            end
         end
         FIRE: begin
            w_spike = w_tf_spike;
            w_vmem  = w_tf_vmem;
            w_pot   = w_tf_vmem;
            w_acc   = '0;
            w_cnt   = '0;
            w_state = TX_REQ;
         end
         TX_REQ: begin
            // R_ack is only honoured once our own request is visible
            if (!r_r_req) begin
               w_r_req = 1'b1;
            end else if (bus.R_ack) begin
               w_r_req = 1'b0;
               w_state = TX_REL;
            end
         end
         TX_REL: begin
            if (!bus.R_ack) w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end

   assign bus.L_ack       = r_l_ack;
   assign bus.R_req       = r_r_req;
   assign bus.R_spike     = r_spike;
   assign bus.R_potential = r_pot;
   assign busy            = (r_state != IDLE);

endmodule

// File: doc/membrane_accum.md
Name: membrane_accum

Overview:
- Clocked consumer stage directly downstream of the two-input partial-sum adder.
- Receives 13-bit partial sums over a four-phase req/ack channel and accumulates NUM_PSUM of them into one output-neuron contribution.
- Adds the contribution to a persistent membrane potential and compares the result against THRESHOLD.
- Emits a spike bit and the post-fire membrane potential over a four-phase output channel to the spike-collection stage.

Parameters:
- WIDTH_IN, 13: partial-sum width; matches the upstream adder output.
- WIDTH_MEM, 16: accumulator and membrane-potential width, unsigned.
- NUM_PSUM, 4: partial sums consumed per timestep; legal range 1..15.
- THRESHOLD, 64: firing threshold; must be less than 2^WIDTH_MEM.
- LEAK, 1: per-timestep leak amount; used only when MEM_LEAK_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- L_req  in  1  input request, four-phase; synchronous to clk.
- L_data  in  WIDTH_IN  partial sum; stable while L_req=1.
- L_ack  out  1  input acknowledge.
- R_req  out  1  output request, four-phase.
- R_ack  in  1  output acknowledge; synchronous to clk.
- R_spike  out  1  1 = neuron fired this timestep.
- R_potential  out  WIDTH_MEM  membrane potential after fire and subtract.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst_n low asynchronously clears the following, regardless of the current state:
  - state to IDLE
  - acc=0, cnt=0, vmem=0
  - L_ack=0, R_req=0, R_spike=0, R_potential=0, busy=0
- A reset during any handshake abandons it. Upstream must observe L_ack=0.
- FSM states: IDLE, RX_ACK, RX_REL, FIRE, TX_REQ, TX_REL.
- IDLE: if L_req=1, go to RX_ACK.
- RX_ACK:
  - acc <= acc + zero-extended L_data, saturating at 2^WIDTH_MEM-1.
  - L_ack <= 1; cnt <= cnt+1; go to RX_REL.
  - L_ack rises 2 cycles after L_req rises.
- RX_REL:
  - Hold L_ack=1 until L_req=0.
  - In the cycle L_req=0 is sampled, L_ack <= 0.
  - If cnt==NUM_PSUM, go to FIRE; otherwise go to IDLE.
  - L_req staying high keeps the block in RX_REL; it never double-counts.
- FIRE, one cycle:
  - sum = vmem + acc, saturating.
  - If sum >= THRESHOLD: R_spike <= 1, vmem <= sum - THRESHOLD.
  - Otherwise: R_spike <= 0, vmem <= sum.
  - R_potential <= the new vmem value.
  - acc <= 0, cnt <= 0; go to TX_REQ.
  - Equality (sum == THRESHOLD) fires, leaving vmem=0.
- TX_REQ: R_req <= 1; wait for R_ack=1, then R_req <= 0 and go to TX_REL.
- TX_REL: wait for R_ack=0, then go to IDLE.
- Output data stability: R_spike and R_potential are stable from the cycle before R_req rises until R_ack falls.
- Output latency: R_req rises 2 cycles after the final L_ack falls.
- Back-pressure: L_req asserted during FIRE/TX states is not acknowledged until IDLE. No input buffering.
- Saturation: acc and sum clamp at all-ones; they never wrap.
- NUM_PSUM=1: every input handshake produces one output handshake.

Optional Feature:
- Macro MEM_LEAK_EN.
- Defined: in FIRE, sum = max(vmem - LEAK, 0) + acc, i.e. leak is applied before the add. vmem clamps at 0 and never underflows.
- Undefined: there is no leak term and LEAK is ignored.

Decomposition:
- Package snn_pkg holds:
  - WIDTH_IN and WIDTH_MEM localparams
  - the state enum typedef (state_t)
  - a sat_add function shared by the acc and sum updates
- Sub-module threshold_fire: combinational; inputs vmem, acc; outputs spike and vmem_next. Includes the leak path under MEM_LEAK_EN.
- The FSM and handshakes stay in membrane_accum.

Test Plan:
- Reset, then NUM_PSUM=4 inputs 10,20,5,15 (acc=50), R_ack responsive -> one output with R_spike=0, R_potential=50.
- Next timestep, inputs 4,4,4,2 (acc=14) -> sum=64 -> R_spike=1, R_potential=0 (equality fires).
- Saturation: vmem=0, inputs 8191 x4 -> acc=32764, R_spike=1, R_potential=32700. Then 8191 x4 x2 more timesteps -> sum clamps at 65535, never wraps. Check for stall and for R_potential=65471.
- Back-pressure: hold R_ack=0 for 20 cycles with the next L_req already high -> L_ack stays 0, R_req/R_spike/R_potential stable; then complete the handshake and verify the next input is accepted.
- Hold L_req=1 for 10 cycles after L_ack rises -> acc counts that sum exactly once; L_ack falls one cycle after L_req falls.
- Assert rst_n=0 in RX_REL with cnt=2 and vmem=30 -> L_ack=0 immediately; the next timestep starts from acc=0, vmem=0. With MEM_LEAK_EN and LEAK=1: vmem=30, acc=0 -> R_potential=29.
